// File: rtl/xbus_arb_if.sv
// Handshake bundle between the xbus round-robin arbiter and the xbuf drivers
// that share one line: per-requester request in, per-driver enable out.
interface xbus_arb_if #(
  parameter int N = 4
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  req;
  logic [N-1:0]  en;
  logic [IW-1:0] gnt_id;
  logic          busy;
  logic          tout;

  modport master (
    input  req,
    output en,
    output gnt_id,
    output busy,
    output tout
  );

  modport slave (
    output req,
    input  en,
    input  gnt_id,
    input  busy,
    input  tout
  );
endinterface

// File: rtl/xbus_arb.sv
// Round-robin owner of the xbuf enables on a shared line, with TURN idle
// cycles between owners. Optional hold timeout: define XBUS_ARB_TIMEOUT_EN.
module xbus_arb #(
  parameter int N       = 4,
  parameter int TURN    = 1,
  parameter int MAXHOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  xbus_arb_if.master bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if (N < 2 || N > 16)             $error("xbus_arb: N out of range 2..16");
  if (TURN < 1 || TURN > 15)       $error("xbus_arb: TURN out of range 1..15");
  if (MAXHOLD < 1 || MAXHOLD > 255) $error("xbus_arb: MAXHOLD out of range 1..255");

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_TURN} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [3:0]    turn_cnt;
  logic [N-1:0]  mreq;
  logic          win_vld;
  logic [IW-1:0] win;
  logic          arb_now;

`ifdef XBUS_ARB_TIMEOUT_EN
  logic [N-1:0] mask;
  logic [7:0]   hold_cnt;
  // A revoked owner stays out of arbitration until it lets go of req once.
  assign mreq = bus.req & ~mask;
`else
  assign mreq = bus.req;
`endif

  assign arb_now = (state == S_IDLE) || (state == S_TURN && turn_cnt == 4'd0);

  // Search starts just past the last owner, so the previous owner is reached last.
  always_comb begin
    int idx;
    // NOTE: every variable gets a default before the loop; a path that left
    // one unassigned would infer a latch.
    idx     = 0;
    win_vld = 1'b0;
    win     = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!win_vld && mreq[idx]) begin
        win_vld = 1'b1;
        win     = IW'(idx);
      end
    end
  end

  // NOTE: state and registered outputs use non-blocking assignments so every
  // branch sees the values from before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ptr      <= IW'(N - 1);
      turn_cnt <= '0;
      bus.en   <= '0;
      bus.gnt_id <= '0;
      bus.busy <= 1'b0;
      bus.tout <= 1'b0;
`ifdef XBUS_ARB_TIMEOUT_EN
      mask     <= '0;
      hold_cnt <= '0;
`endif
    end else begin
      bus.tout <= 1'b0;
`ifdef XBUS_ARB_TIMEOUT_EN
      mask <= mask & bus.req;
`endif
      if (arb_now) begin
        if (win_vld) begin
          state      <= S_OWN;
          bus.en     <= N'(1) << win;
          bus.gnt_id <= win;
          bus.busy   <= 1'b1;
          ptr        <= win;
`ifdef XBUS_ARB_TIMEOUT_EN
          hold_cnt   <= '0;
`endif
        end else begin
          state <= S_IDLE;
        end
      end else if (state == S_TURN) begin
        turn_cnt <= turn_cnt - 4'd1;
      end else if (state == S_OWN) begin
        if (!bus.req[bus.gnt_id]) begin
          state    <= S_TURN;
          bus.en   <= '0;
          bus.busy <= 1'b0;
          turn_cnt <= 4'(TURN - 1);
        end
`ifdef XBUS_ARB_TIMEOUT_EN
        else if (hold_cnt == 8'(MAXHOLD - 1)) begin
          state            <= S_TURN;
          bus.en           <= '0;
          bus.busy         <= 1'b0;
          bus.tout         <= 1'b1;
          turn_cnt         <= 4'(TURN - 1);
          mask[bus.gnt_id] <= 1'b1;
        end else begin
          hold_cnt <= hold_cnt + 8'd1;
        end
`endif
      end
    end
  end
endmodule

// File: tb/tb_xbus_arb.sv
// Directed self-checking bench for xbus_arb: reset, RR contention with TURN=1,
// TURN=3 handoff, reset mid-OWN, and hold timeout (or its absence).
module tb_xbus_arb;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  xbus_arb_if #(.N(4)) bus1 ();
  xbus_arb_if #(.N(4)) bus3 ();

  xbus_arb #(.N(4), .TURN(1), .MAXHOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  xbus_arb #(.N(4), .TURN(3), .MAXHOLD(4)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic [3:0] exp_en, input logic exp_tout);
    check({tag, ".en"},   32'(bus1.en), 32'(exp_en));
    check({tag, ".busy"}, 32'(bus1.busy), 32'(exp_en != 4'b0));
    check({tag, ".tout"}, 32'(bus1.tout), 32'(exp_tout));
    check({tag, ".pop"},  32'($countones(bus1.en) <= 1), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [5];
    order = '{0, 1, 2, 3, 0};

    // Reset held with all requests up.
    rst = 1'b1;
    bus1.req = 4'b1111;
    bus3.req = 4'b0000;
    tick();
    tick();
    chk1("reset", 4'b0000, 1'b0);
    check("reset.gnt_id", 32'(bus1.gnt_id), 32'd0);
    rst = 1'b0;
    tick();
    chk1("first_grant", 4'b0001, 1'b0);

    // Contention: each owner holds 3 cycles, then drops for one edge.
    for (int i = 0; i < 4; i++) begin
      check("rr.gnt_id", 32'(bus1.gnt_id), 32'(order[i]));
      chk1("rr.own0", 4'(1 << order[i]), 1'b0);
      tick();
      chk1("rr.own1", 4'(1 << order[i]), 1'b0);
      tick();
      chk1("rr.own2", 4'(1 << order[i]), 1'b0);
      bus1.req[order[i]] = 1'b0;
      tick();
      chk1("rr.turn", 4'b0000, 1'b0);
      bus1.req = 4'b1111;
      tick();
      chk1("rr.next", 4'(1 << order[i+1]), 1'b0);
    end
    check("rr.wrap_gnt", 32'(bus1.gnt_id), 32'd0);

    // Reset mid-OWN while requester 2 owns the line.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus1.req = 4'b0100;
    tick();
    chk1("mid.own2", 4'b0100, 1'b0);
    rst = 1'b1;
    bus1.req = 4'b0101;
    tick();
    chk1("mid.rst", 4'b0000, 1'b0);
    rst = 1'b0;
    tick();
    chk1("mid.regrant0", 4'b0001, 1'b0);

    // TURN=3 handoff 2 -> 1 on the second instance.
    bus3.req = 4'b0100;
    tick();
    check("t3.own2", 32'(bus3.en), 32'h4);
    bus3.req = 4'b0010;
    tick();
    check("t3.turn_a", 32'(bus3.en), 32'h0);
    tick();
    check("t3.turn_b", 32'(bus3.en), 32'h0);
    tick();
    check("t3.turn_c", 32'(bus3.en), 32'h0);
    tick();
    check("t3.own1", 32'(bus3.en), 32'h2);
    check("t3.gnt_id", 32'(bus3.gnt_id), 32'd1);

    // Stuck requester 0 with requester 3 waiting.
    rst = 1'b1;
    bus1.req = 4'b0000;
    tick();
    rst = 1'b0;
    bus1.req = 4'b1001;
    tick();
    chk1("to.g0", 4'b0001, 1'b0);
`ifdef XBUS_ARB_TIMEOUT_EN
    tick();
    chk1("to.g1", 4'b0001, 1'b0);
    tick();
    chk1("to.g2", 4'b0001, 1'b0);
    tick();
    chk1("to.g3", 4'b0001, 1'b0);
    tick();
    chk1("to.revoke", 4'b0000, 1'b1);
    tick();
    chk1("to.own3", 4'b1000, 1'b0);
    bus1.req = 4'b0001;
    tick();
    chk1("to.rel3", 4'b0000, 1'b0);
    tick();
    chk1("to.masked_a", 4'b0000, 1'b0);
    tick();
    chk1("to.masked_b", 4'b0000, 1'b0);
    bus1.req = 4'b0000;
    tick();
    chk1("to.unmask", 4'b0000, 1'b0);
    bus1.req = 4'b0001;
    tick();
    chk1("to.regrant0", 4'b0001, 1'b0);
`else
    for (int c = 0; c < 10; c++) begin
      tick();
      chk1("hold", 4'b0001, 1'b0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/xbus_arb.md
# xbus_arb

Round-robin arbiter that owns the enable inputs of the tristate `xbuf` drivers sharing one line (e.g. `xmd`). Guarantees at most one driver enabled per cycle and inserts turnaround cycles with all drivers off between owners, so the shared line never sees multi-driver contention (X). Sits beside the driver instances; each requester raises `req[i]` when it wants the line and drives through `xbuf` with `en[i]`.

## Interface
- `N`, 4: number of requesters/drivers, 2..16.
- `TURN`, 1: idle cycles (all `en` low) between two owners, 1..15.
- `MAXHOLD`, 16: max consecutive owned cycles when timeout is compiled in, 1..255.

- `clk`  in  1  clock, all logic on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  N  per-requester bus request, level.
- `en`  out  N  per-driver enable to `xbuf.en`; one-hot or zero.
- `gnt_id`  out  $clog2(N)  index of current owner; valid while `busy`.
- `busy`  out  1  high while any `en` bit is high.
- `tout`  out  1  one-cycle pulse when an owner is revoked by timeout.

## Operation
- All outputs registered. Reset values: `en`=0, `gnt_id`=0, `busy`=0, `tout`=0; state IDLE; RR pointer = N-1 (requester 0 highest priority after reset).
- States: IDLE, OWN, TURN.
- IDLE: at an edge with any unmasked `req` high, select first requester searching from pointer+1 upward with wrap at N; set `en[w]`, `gnt_id`=w, `busy`=1, pointer=w, go OWN. No req: stay.
- OWN: while `req[gnt_id]` sampled high, hold `en`. Edge with `req[gnt_id]` low: clear `en`, `busy`=0, load turn counter TURN-1, go TURN. Other requests never preempt.
- TURN: `en`=0. Counter decrements each edge; at an edge with counter==0, arbitrate exactly as IDLE (grant directly to OWN if any unmasked req, else IDLE).
- Invariant: popcount(`en`) ≤ 1 every cycle; consecutive owners separated by exactly TURN all-zero cycles.
- Same requester may be re-granted only if no other requester is pending (RR from pointer+1 reaches it last).
- Requests dropped during TURN are ignored; requests raised during TURN compete at the TURN exit edge.
- `rst` high at any edge, including mid-OWN: `en` cleared on that edge, state as reset; no turnaround enforced after reset release (line already undriven).

## Timing
- Grant latency from IDLE: `req[i]` rises before edge k, `en[i]` high after edge k (1 cycle).
- Release latency: `req` low sampled at edge k, `en` low after edge k.
- Handoff: owner drops at edge k; next `en` high after edge k+TURN.
- `tout` high for the cycle after the revoking edge only.

## Configuration
- `XBUS_ARB_TIMEOUT_EN` defined: 8-bit hold counter cleared on grant, incremented each OWN cycle; at the edge where owner has held `en` for MAXHOLD cycles, clear `en`, pulse `tout`, go TURN, and mask that requester until its `req` is sampled low once.
- Undefined: no hold counter, no masking, owner keeps line indefinitely; `tout` tied 0; `MAXHOLD` unused.

## Test plan
- Reset: `rst`=1 two cycles with `req`=4'b1111 -> `en`=0, `busy`=0; release -> `en`=4'b0001 one cycle later.
- Contention: `req`=4'b1111 held, each owner drops after 3 cycles -> grant order 0,1,2,3,0, exactly 1 (TURN) zero cycle between owners, popcount(`en`)≤1 throughout.
- Handoff with TURN=3: owner 2 drops at edge k, `req[1]` high -> `en`=0 for 3 cycles, `en`=4'b0010 after edge k+3.
- Reset mid-OWN: assert `rst` while `en`=4'b0100 -> `en`=0 after that edge, next grant goes to 0 if `req[0]` high.
- Timeout (macro on, MAXHOLD=4): `req[0]` stuck high, `req[3]` high -> `en[0]` 4 cycles, `tout` pulse, TURN cycle, `en[3]`; `req[0]` not re-granted until it toggles low.
- Macro off, same stimulus -> `en[0]` held for whole run, `tout` never 1.
